// File: rtl/data_memory_controller_pkg.sv
// Shared encodings for the MEM-stage data memory controller: access sizes,
// FSM state codes, the latched request record and the alignment rule.
package data_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    localparam int MAX_LATENCY = 15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic       is_read;
        logic       is_write;
        logic       conflict;
        logic [1:0] size;
        logic [1:0] addr_lo;
        logic       sign_ext;
    } mem_op_t;

    // Size 11 can never be aligned, so it is folded into the misalign rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = |addr_lo;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_memory_controller_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the
// data memory controller (slave).
interface data_memory_controller_if;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] read_data;
    logic        stall;
    logic        error;

    modport master (
        output mem_read, mem_write, address, write_data, size, sign_ext,
        input  read_data, stall, error
    );

    modport slave (
        input  mem_read, mem_write, address, write_data, size, sign_ext,
        output read_data, stall, error
    );

endinterface

// File: rtl/data_memory_controller_lane_align.sv
// Combinational big-endian lane steering: store byte enables and replicated
// store data, plus right-justified, sign/zero-extended load data.
module data_mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] write_data,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_value,
    output logic        misalign
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Byte offset 0 is the most significant lane.
    always_comb begin
        sel_byte = raw_word[31:24];
        case (addr_lo)
            2'd0:    sel_byte = raw_word[31:24];
            2'd1:    sel_byte = raw_word[23:16];
            2'd2:    sel_byte = raw_word[15:8];
            default: sel_byte = raw_word[7:0];
        endcase
        sel_half = addr_lo[1] ? raw_word[15:0] : raw_word[31:16];
    end

    always_comb begin
        misalign   = is_misaligned(size, addr_lo);
        byte_en    = 4'b0000;
        store_word = write_data;
        load_value = 32'h0;
        case (size)
            SIZE_BYTE: begin
                byte_en    = 4'b1000 >> addr_lo;
                store_word = {4{write_data[7:0]}};
                load_value = {{24{sign_ext & sel_byte[7]}}, sel_byte};
            end
            SIZE_HALF: begin
                byte_en    = addr_lo[1] ? 4'b0011 : 4'b1100;
                store_word = {2{write_data[15:0]}};
                load_value = {{16{sign_ext & sel_half[15]}}, sel_half};
            end
            SIZE_WORD: begin
                byte_en    = 4'b1111;
                store_word = write_data;
                load_value = raw_word;
            end
            default: begin
                byte_en    = 4'b0000;
                load_value = 32'h0;
            end
        endcase
        if (misalign) begin
            byte_en = 4'b0000;
        end
    end

endmodule

// File: rtl/data_memory_controller.sv
// Multi-cycle MEM-stage data memory: latches a request in IDLE, waits
// LATENCY BUSY cycles, then commits the store / registers the load in DONE.
module data_memory_controller
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    data_memory_controller_if.slave  bus
);

    localparam int         ADDR_BITS = $clog2(DEPTH_WORDS);
    localparam logic [3:0] BEAT_LOAD = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("data_memory_controller: LATENCY out of range");
    end

    logic [1:0]           state_q, state_d;
    logic [3:0]           count_q, count_d;
    mem_op_t              op_q, op_d;
    logic [ADDR_BITS-1:0] word_idx_q, word_idx_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          read_data_q, read_data_d;
    logic                 error_q, error_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        request;
    logic        finish;
    logic        access_err;
    logic        commit;
    logic [31:0] raw_word;
    logic [3:0]  byte_en;
    logic [31:0] store_word;
    logic [31:0] load_value;
    logic        misalign;
    logic        unused_addr_bits;

    assign request          = bus.mem_read | bus.mem_write;
    assign finish           = (state_q == ST_BUSY) && (count_q == 4'd0);
    assign access_err       = op_q.conflict | misalign;
    assign commit           = finish && op_q.is_write && !access_err;
    assign raw_word         = mem_q[word_idx_q];
    assign unused_addr_bits = ^bus.address[31:ADDR_BITS+2];

    data_mem_lane_align u_lane_align (
        .size       (op_q.size),
        .addr_lo    (op_q.addr_lo),
        .sign_ext   (op_q.sign_ext),
        .write_data (wdata_q),
        .raw_word   (raw_word),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_value (load_value),
        .misalign   (misalign)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        op_d        = op_q;
        word_idx_d  = word_idx_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        error_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (request) begin
                    state_d    = ST_BUSY;
                    count_d    = BEAT_LOAD;
                    op_d       = '{is_read:  bus.mem_read,
                                   is_write: bus.mem_write,
                                   conflict: bus.mem_read & bus.mem_write,
                                   size:     bus.size,
                                   addr_lo:  bus.address[1:0],
                                   sign_ext: bus.sign_ext};
                    word_idx_d = bus.address[ADDR_BITS+1:2];
                    wdata_d    = bus.write_data;
                end
            end
            ST_BUSY: begin
                if (count_q == 4'd0) begin
                    state_d = ST_DONE;
                    error_d = access_err;
                    if (access_err) begin
                        read_data_d = 32'h0;
                    end else if (op_q.is_read) begin
                        read_data_d = load_value;
                    end
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= 4'd0;
            op_q        <= '0;
            word_idx_q  <= '0;
            wdata_q     <= 32'h0;
            read_data_q <= 32'h0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            op_q        <= op_d;
            word_idx_q  <= word_idx_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            error_q     <= error_d;
        end
    end

    // The array is deliberately not reset; a reset mid-access just drops the store.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx_q][8*b +: 8] <= store_word[8*b +: 8];
                end
            end
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.error     = error_q;
    assign bus.stall     = !rst && (((state_q == ST_IDLE) && request) || (state_q == ST_BUSY));

endmodule

// File: tb/tb_data_memory_controller.sv
// Randomised bench for data_memory_controller: a transaction-level memory
// model predicts Stall/Error/ReadData each cycle, plus literal anchors.
module tb_data_memory_controller;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    localparam logic [1:0] SZB = 2'b00;
    localparam logic [1:0] SZH = 2'b01;
    localparam logic [1:0] SZW = 2'b10;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    bit          check_en    = 1'b0;
    logic        exp_stall   = 1'b0;
    logic        exp_err     = 1'b0;
    logic [31:0] model_rdata = 32'h0;
    logic [31:0] model_mem [int];

    logic        aux_rd;
    logic        aux_wr;
    logic [31:0] aux_addr;
    logic [31:0] aux_wd;
    int          n1;
    int          n15;

    data_memory_controller_if bus ();
    data_memory_controller_if aux1_if ();
    data_memory_controller_if aux15_if ();

    data_memory_controller #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    data_memory_controller #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
        .clk (clk),
        .rst (rst),
        .bus (aux1_if.slave)
    );

    data_memory_controller #(.DEPTH_WORDS(DEPTH), .LATENCY(15)) dut_l15 (
        .clk (clk),
        .rst (rst),
        .bus (aux15_if.slave)
    );

    assign aux1_if.mem_read    = aux_rd;
    assign aux1_if.mem_write   = aux_wr;
    assign aux1_if.address     = aux_addr;
    assign aux1_if.write_data  = aux_wd;
    assign aux1_if.size        = SZW;
    assign aux1_if.sign_ext    = 1'b0;
    assign aux15_if.mem_read   = aux_rd;
    assign aux15_if.mem_write  = aux_wr;
    assign aux15_if.address    = aux_addr;
    assign aux15_if.write_data = aux_wd;
    assign aux15_if.size       = SZW;
    assign aux15_if.sign_ext   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_output("stall", {31'b0, bus.stall}, {31'b0, exp_stall});
            check_output("error", {31'b0, bus.error}, {31'b0, exp_err});
            check_output("read_data", bus.read_data, model_rdata);
        end
    end

    function automatic bit model_bad(input bit rd, input bit wr, input logic [31:0] a, input logic [1:0] sz);
        if (rd && wr) return 1'b1;
        if (sz == 2'b11) return 1'b1;
        if (sz == SZH && a[0]) return 1'b1;
        if (sz == SZW && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input logic [1:0] sz, input bit sx);
        logic [31:0] v;
        if (sz == SZB) begin
            v = (w >> (8 * (3 - off))) & 32'h0000_00FF;
            if (sx && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == SZH) begin
            v = (w >> (8 * (2 - off))) & 32'h0000_FFFF;
            if (sx && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input int off, input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        if (sz == SZB) begin
            sh   = 8 * (3 - off);
            mask = 32'h0000_00FF << sh;
            return (w & ~mask) | ((wd & 32'h0000_00FF) << sh);
        end else if (sz == SZH) begin
            sh   = 8 * (2 - off);
            mask = 32'h0000_FFFF << sh;
            return (w & ~mask) | ((wd & 32'h0000_FFFF) << sh);
        end
        return wd;
    endfunction

    task automatic drive_idle();
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.address    = 32'h0;
        bus.write_data = 32'h0;
        bus.size       = SZW;
        bus.sign_ext   = 1'b0;
    endtask

    task automatic drive_garbage(input bit req);
        bus.mem_read   = req ? 1'b1 : 1'($urandom);
        bus.mem_write  = 1'($urandom);
        bus.address    = $urandom;
        bus.write_data = $urandom;
        bus.size       = 2'($urandom);
        bus.sign_ext   = 1'($urandom);
    endtask

    // Entered and left at posedge+1 of an IDLE cycle.
    task automatic apply_stimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [1:0] sz, input bit sx,
                                  input bit dangle);
        bit err;
        int idx;
        int off;
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.address    = addr;
        bus.write_data = wd;
        bus.size       = sz;
        bus.sign_ext   = sx;
        exp_stall      = 1'b1;
        exp_err        = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            @(posedge clk); #1;
            drive_garbage(1'b0);
        end
        @(posedge clk); #1;
        err = model_bad(rd, wr, addr, sz);
        idx = int'(addr >> 2) % DEPTH;
        off = int'(addr[1:0]);
        if (!model_mem.exists(idx)) model_mem[idx] = 32'h0;
        if (err) begin
            model_rdata = 32'h0;
        end else if (rd) begin
            model_rdata = model_load(model_mem[idx], off, sz, sx);
        end else begin
            model_mem[idx] = model_store(model_mem[idx], off, sz, wd);
        end
        exp_stall = 1'b0;
        exp_err   = err;
        if (dangle) drive_garbage(1'b1);
        else        drive_idle();
        @(posedge clk); #1;
        exp_err = 1'b0;
        drive_idle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        aux_rd   = 1'b0;
        aux_wr   = 1'b0;
        aux_addr = 32'h0;
        aux_wd   = 32'h0;
        drive_idle();
        bus.mem_read = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_en    = 1'b1;
        exp_stall   = 1'b0;
        exp_err     = 1'b0;
        model_rdata = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();
        @(posedge clk); #1;

        for (int i = 0; i < 32; i++) begin
            apply_stimulus(1'b0, 1'b1, 32'(i * 4), $urandom, SZW, 1'b0, 1'b0);
        end

        apply_stimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, SZW, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, SZW, 1'b0, 1'b0);
        check_output("lw_0x10", bus.read_data, 32'hDEADBEEF);
        apply_stimulus(1'b1, 1'b0, 32'h11, 32'h0, SZB, 1'b1, 1'b0);
        check_output("lb_0x11", bus.read_data, 32'hFFFFFFAD);
        apply_stimulus(1'b1, 1'b0, 32'h13, 32'h0, SZB, 1'b0, 1'b0);
        check_output("lbu_0x13", bus.read_data, 32'h000000EF);
        apply_stimulus(1'b1, 1'b0, 32'h12, 32'h0, SZH, 1'b1, 1'b0);
        check_output("lh_0x12", bus.read_data, 32'hFFFFBEEF);
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, SZH, 1'b0, 1'b0);
        check_output("lhu_0x10", bus.read_data, 32'h0000DEAD);
        apply_stimulus(1'b0, 1'b1, 32'h12, 32'h55, SZB, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, SZW, 1'b0, 1'b0);
        check_output("sb_merge", bus.read_data, 32'hDEAD55EF);
        apply_stimulus(1'b1, 1'b0, 32'h02, 32'h0, SZW, 1'b0, 1'b0);
        check_output("lw_misaligned_rdata", bus.read_data, 32'h0);
        apply_stimulus(1'b0, 1'b1, 32'h20, 32'h11223344, SZW, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'h21, 32'hAAAA, SZH, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h20, 32'h0, SZW, 1'b0, 1'b0);
        check_output("sh_misaligned_no_store", bus.read_data, 32'h11223344);
        apply_stimulus(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, SZW, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, SZW, 1'b0, 1'b0);
        check_output("conflict_no_store", bus.read_data, 32'hDEAD55EF);

        apply_stimulus(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, SZW, 1'b0, 1'b0);
        bus.mem_write  = 1'b1;
        bus.address    = 32'h40;
        bus.write_data = 32'h12345678;
        bus.size       = SZW;
        exp_stall      = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b1;
        exp_stall = 1'b0;
        @(posedge clk); #1;
        rst         = 1'b0;
        model_rdata = 32'h0;
        drive_idle();
        @(posedge clk); #1;
        apply_stimulus(1'b1, 1'b0, 32'h40, 32'h0, SZW, 1'b0, 1'b0);
        check_output("rst_abort_keeps_old", bus.read_data, 32'hCAFEF00D);

        apply_stimulus(1'b0, 1'b1, 32'h1000, 32'h0BADF00D, SZW, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, SZW, 1'b0, 1'b0);
        check_output("wrap_0x1000", bus.read_data, 32'h0BADF00D);

        for (int t = 0; t < 200; t++) begin
            int          op;
            logic [31:0] a;
            op = int'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 127)) | (32'($urandom_range(0, 3)) << 12);
            apply_stimulus(op < 3 || op == 7 || op == 6, op >= 3, a, $urandom,
                           2'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        aux_wr   = 1'b1;
        aux_addr = 32'h1000;
        aux_wd   = 32'h13579BDF;
        n1  = 0;
        n15 = 0;
        @(negedge clk);
        if (aux1_if.stall) n1++;
        if (aux15_if.stall) n15++;
        @(posedge clk); #1;
        aux_wr = 1'b0;
        repeat (24) begin
            @(negedge clk);
            if (aux1_if.stall) n1++;
            if (aux15_if.stall) n15++;
        end
        check_output("stall_len_lat1_sw", 32'(n1), 32'd2);
        check_output("stall_len_lat15_sw", 32'(n15), 32'd16);
        @(posedge clk); #1;
        aux_rd   = 1'b1;
        aux_addr = 32'h0;
        n1  = 0;
        n15 = 0;
        @(negedge clk);
        if (aux1_if.stall) n1++;
        if (aux15_if.stall) n15++;
        @(posedge clk); #1;
        aux_rd = 1'b0;
        repeat (24) begin
            @(negedge clk);
            if (aux1_if.stall) n1++;
            if (aux15_if.stall) n15++;
        end
        check_output("stall_len_lat1_lw", 32'(n1), 32'd2);
        check_output("stall_len_lat15_lw", 32'(n15), 32'd16);
        check_output("lat1_wrap_data", aux1_if.read_data, 32'h13579BDF);
        check_output("lat15_wrap_data", aux15_if.read_data, 32'h13579BDF);

        @(posedge clk); #1;
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_controller.md
# data_memory_controller

Multi-cycle data-memory responder for the MIPS pipeline's MEM stage. It accepts MemRead/MemWrite requests with byte, half and word sizes, performs the access after a fixed latency, and drives Stall to freeze the pipeline until the access completes. It replaces the single-cycle data memory behind the MEM stage, with sub-word lane steering, sign/zero extension and misalignment detection.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words (power of 2); ADDR_BITS = log2(DEPTH_WORDS).
- LATENCY, 2: BUSY cycles per access; legal range 1..15.
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset; synchronous, active-high.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- Address  in  32  byte address.
- WriteData  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- Size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as misaligned).
- SignExt  in  1  loads only: 1 = lb/lh sign-extend, 0 = lbu/lhu zero-extend.
- ReadData  out  32  load result; valid only in the DONE cycle, held until the next DONE.
- Stall  out  1  pipeline hold.
- Error  out  1  one-cycle pulse in DONE for a misaligned, illegal-size or conflicting request.

## Operation
- Big-endian byte order: Address[1:0]=0 selects bits [31:24]. Word index = Address[ADDR_BITS+1:2]; upper address bits are ignored, so addresses wrap modulo memory size.
- FSM states: IDLE, BUSY, DONE.
- IDLE → BUSY when MemRead|MemWrite. Address, WriteData, Size, SignExt and the op are latched at that edge; the beat counter loads LATENCY-1.
- BUSY:
  - Counter decrements each cycle; inputs are ignored.
  - At the edge where the counter reaches 0: go to DONE, commit the store via byte enables (other bytes unchanged), register the load result into ReadData.
- DONE → IDLE unconditionally at the next edge.
- Stall = (state==IDLE && (MemRead|MemWrite)) || state==BUSY. This is combinational. It is 0 in DONE and 0 during Rst.
- Error conditions, all latched in IDLE:
  - Size=01 with Address[0]=1.
  - Size=10 with Address[1:0]≠0.
  - Size=11.
  - MemRead&&MemWrite together.
- On an error request: full latency still elapses, no store is committed, ReadData=0, Error=1 in DONE.
- Loads:
  - The selected byte or half is right-justified, then sign- or zero-extended per SignExt.
  - For word loads SignExt is ignored.
- A request present in the DONE cycle is not accepted there. It is sampled in the following IDLE cycle, because the pipeline has just advanced.

## Timing
- Per access: 1 IDLE (request seen, Stall=1) + LATENCY BUSY (Stall=1) + 1 DONE (Stall=0, result valid). Total LATENCY+2 cycles; pipeline advances at the DONE edge.
- Store becomes visible to a load issued in the following request (read-after-write across back-to-back accesses is coherent).
- Reset values: state IDLE, ReadData 0, Error 0, counter 0, latched request cleared. Stall is 0 while Rst=1.
- Rst mid-BUSY aborts the access: no store committed, memory array not cleared, next cycle is IDLE.
- Request deasserted during BUSY: the access still completes (the latched copy governs).

## Structure
- Package data_mem_pkg: Size encodings (SIZE_BYTE/HALF/WORD), FSM state enum, MAX_LATENCY=15.
- Sub-module data_mem_lane_align is combinational. It takes latched Size, Address[1:0], SignExt, WriteData and the raw read word. It outputs 4-bit byte enables, the lane-replicated store word, the extended load value and a misalign flag.
- Top level holds the FSM, counter, latches, memory array and ReadData register.

## Test plan
- LATENCY=2, sw 0xDEADBEEF to 0x10, then lw 0x10 → Stall high 3 cycles per access; ReadData=0xDEADBEEF in the second DONE; Error=0.
- After that, lb 0x11 SignExt=1 → 0xFFFFFFAD. lbu 0x13 → 0x000000EF. lh 0x12 SignExt=1 → 0xFFFFBEEF. lhu 0x10 → 0x0000DEAD.
- sb 0x55 to 0x12 over 0xDEADBEEF, then lw 0x10 → 0xDEAD55EF.
- lw 0x02 → Error pulse in DONE, ReadData=0. sh to 0x21 → Error, memory word at 0x20 unchanged. MemRead&MemWrite together → Error.
- Rst asserted in the first BUSY cycle of sw 0x12345678 to 0x40 → IDLE next cycle, Stall=0, later lw 0x40 returns the pre-existing value.
- DEPTH_WORDS=1024: sw to 0x1000 then lw 0x0 → same data (wrap). Sweep LATENCY=1 and 15 → Stall length LATENCY+1 cycles.
